// File: rtl/erx_pkg.sv
// Shared definitions for the eLink receive deframer: byte positions of the
// transaction fields, burst address step, FSM states and the header record.
package erx_pkg;

    localparam int FRAME_BYTES = 14;
    localparam int BYTE_CMD    = 0;
    localparam int BYTE_HDR    = 1;
    localparam int BYTE_DATA   = 6;
    localparam int BYTE_SRC    = 10;
    localparam int INCR_BIT    = 2;
    localparam int PKT_W       = 104;

    localparam logic [31:0] BURST_INCR = 32'd8;

    // Byte i of a transaction lives at element [i], i.e. bits [8*i+7:8*i].
    typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HDR,
        ST_BURST
    } state_t;

    typedef struct packed {
        logic [3:0]  ctrlmode;
        logic [31:0] dstaddr;
        logic [1:0]  datamode;
        logic        write;
        logic        access;
        logic        incr;
    } hdr_t;

endpackage

// File: rtl/erx_pkt_fifo.sv
// Single-clock first-word-fall-through packet FIFO; a push into a full FIFO is
// ignored unless a pop happens on the same edge.
module erx_pkt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 105
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/erx_deframer.sv
// eLink receive deframer: assembles DDR beats into 112-bit transactions, decodes
// them into emesh packets, expands bursts and buffers packets with pushback.
module erx_deframer
    import erx_pkg::*;
#(
    parameter int LW          = 16,
    parameter int PW          = 104,
    parameter int DEPTH       = 4,
    parameter int WAIT_MARGIN = 2,
    parameter int BURST_EN    = 1
) (
    input  logic          rx_lclk,
    input  logic          erx_nreset,
    input  logic          rx_frame,
    input  logic [LW-1:0] rx_word,
    output logic          out_access,
    output logic [PW-1:0] out_packet,
    output logic          out_burst,
    input  logic          out_wait,
    output logic          rx_wait,
    output logic          err_short,
    output logic          err_overflow,
    input  logic          err_clear
);

    localparam int BPB     = LW / 8;
    localparam int BEATS   = FRAME_BYTES * 8 / LW;
    localparam int BEATS_B = 64 / LW;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;

    state_t        state_q, state_d;
    logic [3:0]    beat_q, beat_d;
    frame_t        frm_q, asm_frame;
    hdr_t          hdr_q, hdr_dec, hdr_cur;
    logic [3:0]    wr_byte;
    logic          capture, push, push_burst, set_short;
    logic          pop, drop;
    logic          err_short_q, err_short_d;
    logic          err_ovf_q, err_ovf_d;
    logic          rx_wait_q, rx_wait_d;
    logic [31:0]   data_w, src_w;
    logic [PKT_W-1:0] pkt;
    logic [PW:0]   fifo_din, fifo_dout;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count, cnt_next, free_slots;
    logic          unused_b0;

    always_ff @(posedge rx_lclk or negedge erx_nreset) begin
        if (!erx_nreset) begin
            state_q     <= ST_SYNC;
            beat_q      <= '0;
            frm_q       <= '0;
            hdr_q       <= '0;
            err_short_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            rx_wait_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            err_short_q <= err_short_d;
            err_ovf_q   <= err_ovf_d;
            rx_wait_q   <= rx_wait_d;
            if (capture) frm_q <= asm_frame;
            if (push)    hdr_q <= hdr_cur;
        end
    end

    // In BURST, beat 0 is also the cycle that decides whether the frame continues.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        capture    = 1'b0;
        push       = 1'b0;
        push_burst = 1'b0;
        set_short  = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (!rx_frame) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rx_frame) begin
                    capture = 1'b1;
                    beat_d  = 4'd1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!rx_frame) begin
                    set_short = 1'b1;
                    beat_d    = '0;
                    state_d   = ST_IDLE;
                end else begin
                    capture = 1'b1;
                    if (beat_q == 4'(BEATS - 1)) begin
                        push    = 1'b1;
                        beat_d  = '0;
                        state_d = ST_BURST;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            ST_BURST: begin
                if (beat_q == '0) begin
                    if (!rx_frame) begin
                        state_d = ST_IDLE;
                    end else if (BURST_EN == 0) begin
                        set_short = 1'b1;
                        state_d   = ST_SYNC;
                    end else begin
                        capture = 1'b1;
                        beat_d  = 4'd1;
                    end
                end else if (!rx_frame) begin
                    set_short = 1'b1;
                    beat_d    = '0;
                    state_d   = ST_IDLE;
                end else begin
                    capture = 1'b1;
                    if (beat_q == 4'(BEATS_B - 1)) begin
                        push       = 1'b1;
                        push_burst = 1'b1;
                        beat_d     = '0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_comb begin
        asm_frame = frm_q;
        wr_byte   = (state_q == ST_BURST ? 4'(BYTE_DATA) : 4'd0) + 4'(int'(beat_q) * BPB);
        if (capture) begin
            for (int j = 0; j < BPB; j++) begin
                asm_frame[wr_byte + 4'(j)] = rx_word[8*j +: 8];
            end
        end
    end

    // Continuation packets reuse the held header and only advance the address.
    always_comb begin
        hdr_dec.ctrlmode = asm_frame[BYTE_HDR][7:4];
        hdr_dec.dstaddr  = {asm_frame[BYTE_HDR][3:0], asm_frame[BYTE_HDR+1],
                            asm_frame[BYTE_HDR+2], asm_frame[BYTE_HDR+3],
                            asm_frame[BYTE_HDR+4][7:4]};
        hdr_dec.datamode = asm_frame[BYTE_HDR+4][3:2];
        hdr_dec.write    = asm_frame[BYTE_HDR+4][1];
        hdr_dec.access   = asm_frame[BYTE_HDR+4][0];
        hdr_dec.incr     = ~asm_frame[BYTE_CMD][INCR_BIT];
        hdr_cur = hdr_dec;
        if (state_q == ST_BURST) begin
            hdr_cur = hdr_q;
            if (hdr_q.incr) hdr_cur.dstaddr = hdr_q.dstaddr + BURST_INCR;
        end
    end

    assign unused_b0 = ^{asm_frame[BYTE_CMD][7:3], asm_frame[BYTE_CMD][1:0]};

    assign data_w = {asm_frame[BYTE_DATA], asm_frame[BYTE_DATA+1],
                     asm_frame[BYTE_DATA+2], asm_frame[BYTE_DATA+3]};
    assign src_w  = {asm_frame[BYTE_SRC], asm_frame[BYTE_SRC+1],
                     asm_frame[BYTE_SRC+2], asm_frame[BYTE_SRC+3]};
    assign pkt    = {src_w, data_w, hdr_cur.dstaddr, hdr_cur.ctrlmode,
                     hdr_cur.datamode, hdr_cur.write, hdr_cur.access};
    assign fifo_din = {push_burst, PW'(pkt)};

    assign pop        = out_access & ~out_wait;
    assign drop       = push & fifo_full & ~pop;
    assign cnt_next   = fifo_count + CW'(push & ~drop) - CW'(pop);
    assign free_slots = CW'(DEPTH) - cnt_next;

    // A set on the same edge as a clear wins, so no error event is lost.
    always_comb begin
        err_short_d = set_short | (err_short_q & ~err_clear);
        err_ovf_d   = drop | (err_ovf_q & ~err_clear);
        rx_wait_d   = (free_slots <= CW'(WAIT_MARGIN));
    end

    erx_pkt_fifo #(
        .DEPTH (DEPTH),
        .W     (PW + 1)
    ) u_fifo (
        .clk_i   (rx_lclk),
        .rst_ni  (erx_nreset),
        .push_i  (push),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign out_access   = ~fifo_empty;
    assign out_packet   = out_access ? fifo_dout[PW-1:0] : '0;
    assign out_burst    = out_access & fifo_dout[PW];
    assign rx_wait      = rx_wait_q;
    assign err_short    = err_short_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_erx_deframer.sv
// Directed bench for erx_deframer: one LW=16 burst-capable instance and one
// LW=8 instance with bursts disabled, checked against hand-built packets.
module tb_erx_deframer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         erxNreset;
    logic         frame16, outWait16, errClear16;
    logic [15:0]  word16;
    logic         access16, burst16, rxWait16, errShort16, errOvf16;
    logic [103:0] packet16;
    logic         frame8, outWait8, errClear8;
    logic [7:0]   word8;
    logic         access8, burst8, rxWait8, errShort8, errOvf8;
    logic [103:0] packet8;

    int testsRun  = 0;
    int failCount = 0;

    logic [111:0] fr, frB, frC;
    logic [103:0] expA, expB, expC;

    erx_deframer #(.LW(16), .PW(104), .DEPTH(4), .WAIT_MARGIN(2), .BURST_EN(1)) dut (
        .rx_lclk(clock), .erx_nreset(erxNreset), .rx_frame(frame16), .rx_word(word16),
        .out_access(access16), .out_packet(packet16), .out_burst(burst16),
        .out_wait(outWait16), .rx_wait(rxWait16), .err_short(errShort16),
        .err_overflow(errOvf16), .err_clear(errClear16)
    );

    erx_deframer #(.LW(8), .PW(104), .DEPTH(4), .WAIT_MARGIN(2), .BURST_EN(0)) dut8 (
        .rx_lclk(clock), .erx_nreset(erxNreset), .rx_frame(frame8), .rx_word(word8),
        .out_access(access8), .out_packet(packet8), .out_burst(burst8),
        .out_wait(outWait8), .rx_wait(rxWait8), .err_short(errShort8),
        .err_overflow(errOvf8), .err_clear(errClear8)
    );

    // Byte i of the transaction sits at bits [8*i+7:8*i].
    function automatic logic [111:0] makeFrame(input logic incr, input logic [3:0] ctrl,
                                               input logic [31:0] dst, input logic [31:0] data,
                                               input logic [31:0] src);
        logic [7:0]   b [14];
        logic [111:0] f;
        b[0]  = incr ? 8'h00 : 8'h04;
        b[1]  = {ctrl, dst[31:28]};
        b[2]  = dst[27:20];
        b[3]  = dst[19:12];
        b[4]  = dst[11:4];
        b[5]  = {dst[3:0], 2'b10, 1'b1, 1'b1};
        b[6]  = data[31:24];
        b[7]  = data[23:16];
        b[8]  = data[15:8];
        b[9]  = data[7:0];
        b[10] = src[31:24];
        b[11] = src[23:16];
        b[12] = src[15:8];
        b[13] = src[7:0];
        for (int i = 0; i < 14; i++) f[8*i +: 8] = b[i];
        return f;
    endfunction

    function automatic logic [103:0] expPkt(input logic [3:0] ctrl, input logic [31:0] dst,
                                            input logic [31:0] data, input logic [31:0] src);
        return {src, data, dst, ctrl, 2'b10, 1'b1, 1'b1};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic [15:0] w);
        frame16 = f;
        word16  = w;
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus8(input logic f, input logic [7:0] w);
        frame8 = f;
        word8  = w;
        @(posedge clock);
        #1;
    endtask

    task automatic sendBeats16(input logic [111:0] f, input int first, input int count);
        for (int k = first; k < first + count; k++) applyStimulus(1'b1, f[16*k +: 16]);
    endtask

    task automatic checkHead(input string tag, input logic [103:0] pkt, input logic burst);
        checkOutput({tag, "_access"}, access16, 1'b1);
        checkOutput({tag, "_packet"}, packet16, pkt);
        checkOutput({tag, "_burst"}, burst16, burst);
    endtask

    initial begin
        erxNreset = 1'b0;
        frame16 = 1'b0; word16 = '0; outWait16 = 1'b0; errClear16 = 1'b0;
        frame8  = 1'b0; word8  = '0; outWait8  = 1'b0; errClear8  = 1'b0;
        #22;
        checkOutput("rst_access", access16, 1'b0);
        checkOutput("rst_packet", packet16, 104'h0);
        checkOutput("rst_burst", burst16, 1'b0);
        checkOutput("rst_rx_wait", rxWait16, 1'b0);
        checkOutput("rst_err_short", errShort16, 1'b0);
        checkOutput("rst_err_overflow", errOvf16, 1'b0);
        checkOutput("rst_access8", access8, 1'b0);
        @(negedge clock);
        erxNreset = 1'b1;
        applyStimulus(1'b0, 16'h0);
        applyStimulus(1'b0, 16'h0);

        // Single write
        fr = makeFrame(1'b1, 4'h0, 32'h8080_0010, 32'hDEAD_BEEF, 32'h1234_5678);
        sendBeats16(fr, 0, 6);
        checkOutput("single_pre_final_access", access16, 1'b0);
        sendBeats16(fr, 6, 1);
        checkHead("single", expPkt(4'h0, 32'h8080_0010, 32'hDEAD_BEEF, 32'h1234_5678), 1'b0);
        applyStimulus(1'b0, 16'h0);
        checkOutput("single_popped", access16, 1'b0);

        // Incrementing burst of three across a 4K boundary
        outWait16 = 1'b1;
        fr  = makeFrame(1'b1, 4'h3, 32'h0000_0FF8, 32'h1111_1111, 32'hAAAA_0001);
        frB = makeFrame(1'b1, 4'h3, 32'h0000_0FF8, 32'h2222_2222, 32'hAAAA_0002);
        frC = makeFrame(1'b1, 4'h3, 32'h0000_0FF8, 32'h3333_3333, 32'hAAAA_0003);
        sendBeats16(fr, 0, 7);
        sendBeats16(frB, 3, 4);
        sendBeats16(frC, 3, 4);
        applyStimulus(1'b0, 16'h0);
        outWait16 = 1'b0;
        checkHead("burst_p0", expPkt(4'h3, 32'h0000_0FF8, 32'h1111_1111, 32'hAAAA_0001), 1'b0);
        applyStimulus(1'b0, 16'h0);
        checkHead("burst_p1", expPkt(4'h3, 32'h0000_1000, 32'h2222_2222, 32'hAAAA_0002), 1'b1);
        applyStimulus(1'b0, 16'h0);
        checkHead("burst_p2", expPkt(4'h3, 32'h0000_1008, 32'h3333_3333, 32'hAAAA_0003), 1'b1);
        applyStimulus(1'b0, 16'h0);
        checkOutput("burst_drained", access16, 1'b0);
        checkOutput("burst_no_short", errShort16, 1'b0);

        // Address wrap at 2^32
        outWait16 = 1'b1;
        fr  = makeFrame(1'b1, 4'h1, 32'hFFFF_FFF8, 32'h4444_4444, 32'hBBBB_0001);
        frB = makeFrame(1'b1, 4'h1, 32'hFFFF_FFF8, 32'h5555_5555, 32'hBBBB_0002);
        sendBeats16(fr, 0, 7);
        sendBeats16(frB, 3, 4);
        applyStimulus(1'b0, 16'h0);
        outWait16 = 1'b0;
        checkHead("wrap_p0", expPkt(4'h1, 32'hFFFF_FFF8, 32'h4444_4444, 32'hBBBB_0001), 1'b0);
        applyStimulus(1'b0, 16'h0);
        checkHead("wrap_p1", expPkt(4'h1, 32'h0000_0000, 32'h5555_5555, 32'hBBBB_0002), 1'b1);
        applyStimulus(1'b0, 16'h0);

        // Non-incrementing burst keeps the address
        outWait16 = 1'b1;
        fr  = makeFrame(1'b0, 4'h2, 32'h0000_0100, 32'h6666_6666, 32'hCCCC_0001);
        frB = makeFrame(1'b0, 4'h2, 32'h0000_0100, 32'h7777_7777, 32'hCCCC_0002);
        sendBeats16(fr, 0, 7);
        sendBeats16(frB, 3, 4);
        applyStimulus(1'b0, 16'h0);
        outWait16 = 1'b0;
        applyStimulus(1'b0, 16'h0);
        checkHead("fixed_p1", expPkt(4'h2, 32'h0000_0100, 32'h7777_7777, 32'hCCCC_0002), 1'b1);
        applyStimulus(1'b0, 16'h0);

        // Short frame, recovery, clear and set-beats-clear
        fr = makeFrame(1'b1, 4'h0, 32'h0000_2000, 32'h0BAD_0BAD, 32'h0000_0001);
        sendBeats16(fr, 0, 4);
        applyStimulus(1'b0, 16'h0);
        checkOutput("short_err", errShort16, 1'b1);
        checkOutput("short_no_packet", access16, 1'b0);
        fr = makeFrame(1'b1, 4'h7, 32'h0000_3000, 32'h600D_600D, 32'h0000_0002);
        sendBeats16(fr, 0, 7);
        checkHead("short_recover", expPkt(4'h7, 32'h0000_3000, 32'h600D_600D, 32'h0000_0002), 1'b0);
        applyStimulus(1'b0, 16'h0);
        errClear16 = 1'b1;
        applyStimulus(1'b0, 16'h0);
        errClear16 = 1'b0;
        checkOutput("short_cleared", errShort16, 1'b0);
        sendBeats16(fr, 0, 3);
        errClear16 = 1'b1;
        applyStimulus(1'b0, 16'h0);
        errClear16 = 1'b0;
        checkOutput("short_set_beats_clear", errShort16, 1'b1);
        errClear16 = 1'b1;
        applyStimulus(1'b0, 16'h0);
        errClear16 = 1'b0;

        // Overflow with the consumer stalled
        outWait16 = 1'b1;
        for (int p = 0; p < 5; p++) begin
            fr = makeFrame(1'b1, 4'h0, 32'h0000_1000 + 32'(p * 16), 32'hC0DE_0000 + 32'(p), 32'h5000 + 32'(p));
            sendBeats16(fr, 0, 7);
            applyStimulus(1'b0, 16'h0);
            if (p == 0) checkOutput("ovf_wait_after_push1", rxWait16, 1'b0);
            if (p == 1) checkOutput("ovf_wait_after_push2", rxWait16, 1'b1);
            if (p == 3) checkOutput("ovf_err_after_push4", errOvf16, 1'b0);
            if (p == 4) checkOutput("ovf_err_after_push5", errOvf16, 1'b1);
        end
        outWait16 = 1'b0;
        for (int p = 0; p < 4; p++) begin
            checkHead($sformatf("ovf_drain%0d", p),
                      expPkt(4'h0, 32'h0000_1000 + 32'(p * 16), 32'hC0DE_0000 + 32'(p), 32'h5000 + 32'(p)), 1'b0);
            applyStimulus(1'b0, 16'h0);
        end
        checkOutput("ovf_drained", access16, 1'b0);
        checkOutput("ovf_wait_released", rxWait16, 1'b0);
        errClear16 = 1'b1;
        applyStimulus(1'b0, 16'h0);
        errClear16 = 1'b0;
        checkOutput("ovf_cleared", errOvf16, 1'b0);

        // Reset in the middle of a burst with the frame held high
        outWait16 = 1'b1;
        fr  = makeFrame(1'b1, 4'h4, 32'h0000_4000, 32'h1357_9BDF, 32'h0000_0003);
        frB = makeFrame(1'b1, 4'h4, 32'h0000_4000, 32'h2468_ACE0, 32'h0000_0004);
        sendBeats16(fr, 0, 7);
        sendBeats16(frB, 3, 2);
        checkOutput("rst_mid_pre_access", access16, 1'b1);
        #2 erxNreset = 1'b0;
        #1;
        checkOutput("rst_mid_access", access16, 1'b0);
        checkOutput("rst_mid_packet", packet16, 104'h0);
        checkOutput("rst_mid_burst", burst16, 1'b0);
        checkOutput("rst_mid_rx_wait", rxWait16, 1'b0);
        @(posedge clock);
        #1;
        erxNreset = 1'b1;
        outWait16 = 1'b0;
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, fr[16*(k % 7) +: 16]);
        checkOutput("rst_mid_frame_ignored", access16, 1'b0);
        applyStimulus(1'b0, 16'h0);
        sendBeats16(fr, 0, 7);
        checkHead("rst_mid_resync", expPkt(4'h4, 32'h0000_4000, 32'h1357_9BDF, 32'h0000_0003), 1'b0);
        applyStimulus(1'b0, 16'h0);

        // Byte-wide instance without bursts
        outWait8 = 1'b1;
        fr = makeFrame(1'b1, 4'h5, 32'h4000_0020, 32'hCAFE_F00D, 32'h8765_4321);
        for (int k = 0; k < 13; k++) applyStimulus8(1'b1, fr[8*k +: 8]);
        checkOutput("lw8_pre_final_access", access8, 1'b0);
        applyStimulus8(1'b1, fr[8*13 +: 8]);
        checkOutput("lw8_access", access8, 1'b1);
        checkOutput("lw8_packet", packet8, expPkt(4'h5, 32'h4000_0020, 32'hCAFE_F00D, 32'h8765_4321));
        checkOutput("lw8_burst", burst8, 1'b0);
        applyStimulus8(1'b1, 8'hAB);
        checkOutput("lw8_err_short", errShort8, 1'b1);
        for (int k = 0; k < 8; k++) applyStimulus8(1'b1, 8'h30 + 8'(k));
        outWait8 = 1'b0;
        applyStimulus8(1'b1, 8'h55);
        checkOutput("lw8_single_packet_only", access8, 1'b0);
        applyStimulus8(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
